// File: rtl/axicb_pkg.sv
// Shared definitions for the crossbar: AXI response codes and the guard FSM states.
package axicb_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } guard_state_t;

endpackage

// File: rtl/axicb_slv_id_fifo.sv
// Show-ahead synchronous FIFO holding the IDs (and read lengths) of outstanding requests.
module axicb_slv_id_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             aclk,
  input  logic             srst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  always_ff @(posedge aclk) begin
    if (srst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (!push && pop)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (push)
      mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/axicb_slv_guard.sv
// Slave-side guard: outstanding limits, ID/length tracking and a watchdog that
// answers every pending transaction with SLVERR once the slave goes silent.
module axicb_slv_guard
  import axicb_pkg::*;
#(
  parameter int AXI_ADDR_W     = 8,
  parameter int AXI_ID_W       = 8,
  parameter int AXI_DATA_W     = 8,
  parameter int AXI_SIGNALING  = 0,
  parameter int MAX_OSTDREQ    = 4,
  parameter int TIMEOUT_ENABLE = 1,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int AWCH_W         = 8,
  parameter int WCH_W          = 8,
  parameter int BCH_W          = 8,
  parameter int ARCH_W         = 8,
  parameter int RCH_W          = 8
) (
  input  logic              aclk,
  input  logic              srst,
  input  logic              i_awvalid,
  output logic              i_awready,
  input  logic [AWCH_W-1:0] i_awch,
  input  logic              i_wvalid,
  output logic              i_wready,
  input  logic              i_wlast,
  input  logic [WCH_W-1:0]  i_wch,
  output logic              i_bvalid,
  input  logic              i_bready,
  output logic [BCH_W-1:0]  i_bch,
  input  logic              i_arvalid,
  output logic              i_arready,
  input  logic [ARCH_W-1:0] i_arch,
  output logic              i_rvalid,
  input  logic              i_rready,
  output logic              i_rlast,
  output logic [RCH_W-1:0]  i_rch,
  output logic              o_awvalid,
  input  logic              o_awready,
  output logic [AWCH_W-1:0] o_awch,
  output logic              o_wvalid,
  input  logic              o_wready,
  output logic              o_wlast,
  output logic [WCH_W-1:0]  o_wch,
  input  logic              o_bvalid,
  output logic              o_bready,
  input  logic [BCH_W-1:0]  o_bch,
  output logic              o_arvalid,
  input  logic              o_arready,
  output logic [ARCH_W-1:0] o_arch,
  input  logic              o_rvalid,
  output logic              o_rready,
  input  logic              o_rlast,
  input  logic [RCH_W-1:0]  o_rch,
  output logic              wr_timeout,
  output logic              rd_timeout
);

  localparam int              WD_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam int              RD_ENT_W = AXI_ID_W + 8;

  guard_state_t wr_state, wr_state_nxt;
  guard_state_t rd_state, rd_state_nxt;

  logic [AXI_ID_W-1:0] aw_id, ar_id, wr_head_id, rd_head_id;
  logic [7:0]          ar_len, rd_head_len, rd_beat;
  logic [RD_ENT_W-1:0] rd_head;
  logic                wr_push, wr_pop, wr_full, wr_empty, wr_resp_hs;
  logic                rd_push, rd_pop, rd_full, rd_empty, rd_resp_hs;
  logic                rd_beat_inc, rd_beat_clr;
  logic [WD_W-1:0]     wr_wd, rd_wd;

  logic [AXI_ID_W+1:0]            wr_err;
  logic [AXI_ID_W+AXI_DATA_W+1:0] rd_err;

  assign aw_id = i_awch[AWCH_W-1 -: AXI_ID_W];
  assign ar_id = i_arch[ARCH_W-1 -: AXI_ID_W];

  generate
    if (AXI_SIGNALING > 0) begin : g_len
      assign ar_len = i_arch[AXI_ADDR_W +: 8];
    end else begin : g_no_len
      assign ar_len = '0;
    end
  endgenerate

  assign {rd_head_id, rd_head_len} = rd_head;
  assign wr_err = {RESP_SLVERR, wr_head_id};
  assign rd_err = {RESP_SLVERR, rd_head_id, {AXI_DATA_W{1'b0}}};

  assign o_awch  = i_awch;
  assign o_wch   = i_wch;
  assign o_wlast = i_wlast;
  assign o_arch  = i_arch;

  assign wr_timeout = (wr_state == FLUSH);
  assign rd_timeout = (rd_state == FLUSH);

  axicb_slv_id_fifo #(
    .WIDTH (AXI_ID_W),
    .DEPTH (MAX_OSTDREQ)
  ) u_wr_fifo (
    .aclk      (aclk),
    .srst      (srst),
    .push      (wr_push),
    .push_data (aw_id),
    .pop       (wr_pop),
    .head      (wr_head_id),
    .full      (wr_full),
    .empty     (wr_empty)
  );

  axicb_slv_id_fifo #(
    .WIDTH (RD_ENT_W),
    .DEPTH (MAX_OSTDREQ)
  ) u_rd_fifo (
    .aclk      (aclk),
    .srst      (srst),
    .push      (rd_push),
    .push_data ({ar_id, ar_len}),
    .pop       (rd_pop),
    .head      (rd_head),
    .full      (rd_full),
    .empty     (rd_empty)
  );

  always_ff @(posedge aclk) begin
    if (srst) begin
      wr_state <= RUN;
      rd_state <= RUN;
      wr_wd    <= '0;
      rd_wd    <= '0;
      rd_beat  <= '0;
    end else begin
      wr_state <= wr_state_nxt;
      rd_state <= rd_state_nxt;
      wr_wd <= (TIMEOUT_ENABLE == 0 || wr_state == FLUSH || wr_empty || wr_resp_hs) ?
               '0 : wr_wd + 1'b1;
      rd_wd <= (TIMEOUT_ENABLE == 0 || rd_state == FLUSH || rd_empty || rd_resp_hs) ?
               '0 : rd_wd + 1'b1;
      if (rd_beat_clr)
        rd_beat <= '0;
      else if (rd_beat_inc)
        rd_beat <= rd_beat + 1'b1;
    end
  end

  // A slave response in the expiry cycle suppresses the flush.
  always_comb begin
    wr_state_nxt = wr_state;
    o_awvalid    = i_awvalid & ~wr_full;
    i_awready    = o_awready & ~wr_full;
    o_wvalid     = i_wvalid;
    i_wready     = o_wready;
    o_bready     = wr_empty | i_bready;
    i_bvalid     = o_bvalid & ~wr_empty;
    i_bch        = o_bch;
    wr_pop       = o_bvalid & i_bready & ~wr_empty;
    wr_resp_hs   = o_bvalid & o_bready;
    if (wr_state == RUN) begin
      if (TIMEOUT_ENABLE != 0 && !wr_empty && !wr_resp_hs && wr_wd == WD_LAST)
        wr_state_nxt = FLUSH;
    end else begin
      o_awvalid  = 1'b0;
      i_awready  = 1'b0;
      o_wvalid   = 1'b0;
      i_wready   = 1'b1;
      o_bready   = 1'b1;
      i_bvalid   = ~wr_empty;
      i_bch      = BCH_W'(wr_err);
      wr_pop     = ~wr_empty & i_bready;
      wr_resp_hs = 1'b0;
      if (wr_empty)
        wr_state_nxt = RUN;
    end
    wr_push = i_awvalid & i_awready;
  end

  // Flush beats resume from the beat counter so a half-delivered burst ends on ARLEN.
  always_comb begin
    rd_state_nxt = rd_state;
    o_arvalid    = i_arvalid & ~rd_full;
    i_arready    = o_arready & ~rd_full;
    o_rready     = rd_empty | i_rready;
    i_rvalid     = o_rvalid & ~rd_empty;
    i_rlast      = o_rlast;
    i_rch        = o_rch;
    rd_beat_inc  = o_rvalid & i_rready & ~rd_empty;
    rd_beat_clr  = rd_beat_inc & o_rlast;
    rd_resp_hs   = o_rvalid & o_rready;
    if (rd_state == RUN) begin
      if (TIMEOUT_ENABLE != 0 && !rd_empty && !rd_resp_hs && rd_wd == WD_LAST)
        rd_state_nxt = FLUSH;
    end else begin
      o_arvalid   = 1'b0;
      i_arready   = 1'b0;
      o_rready    = 1'b1;
      i_rvalid    = ~rd_empty;
      i_rlast     = (rd_beat == rd_head_len);
      i_rch       = RCH_W'(rd_err);
      rd_beat_inc = ~rd_empty & i_rready;
      rd_beat_clr = rd_beat_inc & i_rlast;
      rd_resp_hs  = 1'b0;
      if (rd_empty)
        rd_state_nxt = RUN;
    end
    rd_pop  = rd_beat_clr;
    rd_push = i_arvalid & i_arready;
  end

endmodule

// File: tb/tb_axicb_slv_guard.sv
// Directed bench for axicb_slv_guard: switch-side B/R responses are checked by a
// scoreboard monitor, flags and handshake gating by inline checks.
module tb_axicb_slv_guard;

  localparam int ADDR_W = 8;
  localparam int ID_W   = 4;
  localparam int DATA_W = 8;
  localparam int AW_W   = ID_W + ADDR_W;
  localparam int W_W    = 8;
  localparam int B_W    = 2 + ID_W;
  localparam int AR_W   = ID_W + 8 + ADDR_W;
  localparam int R_W    = 2 + ID_W + DATA_W;

  logic            aclk, srst;
  logic            i_awvalid, i_awready, i_wvalid, i_wready, i_wlast, i_bvalid, i_bready;
  logic            i_arvalid, i_arready, i_rvalid, i_rready, i_rlast;
  logic [AW_W-1:0] i_awch, o_awch;
  logic [W_W-1:0]  i_wch, o_wch;
  logic [B_W-1:0]  i_bch, o_bch;
  logic [AR_W-1:0] i_arch, o_arch;
  logic [R_W-1:0]  i_rch, o_rch;
  logic            o_awvalid, o_awready, o_wvalid, o_wready, o_wlast, o_bvalid, o_bready;
  logic            o_arvalid, o_arready, o_rvalid, o_rready, o_rlast;
  logic            wr_timeout, rd_timeout;

  int n_cmp = 0;
  int n_err = 0;
  logic [B_W-1:0] exp_b[$];
  logic [R_W:0]   exp_r[$];

  axicb_slv_guard #(
    .AXI_ADDR_W     (ADDR_W),
    .AXI_ID_W       (ID_W),
    .AXI_DATA_W     (DATA_W),
    .AXI_SIGNALING  (1),
    .MAX_OSTDREQ    (4),
    .TIMEOUT_ENABLE (1),
    .TIMEOUT_CYCLES (16),
    .AWCH_W         (AW_W),
    .WCH_W          (W_W),
    .BCH_W          (B_W),
    .ARCH_W         (AR_W),
    .RCH_W          (R_W)
  ) dut (
    .aclk       (aclk),
    .srst       (srst),
    .i_awvalid  (i_awvalid),
    .i_awready  (i_awready),
    .i_awch     (i_awch),
    .i_wvalid   (i_wvalid),
    .i_wready   (i_wready),
    .i_wlast    (i_wlast),
    .i_wch      (i_wch),
    .i_bvalid   (i_bvalid),
    .i_bready   (i_bready),
    .i_bch      (i_bch),
    .i_arvalid  (i_arvalid),
    .i_arready  (i_arready),
    .i_arch     (i_arch),
    .i_rvalid   (i_rvalid),
    .i_rready   (i_rready),
    .i_rlast    (i_rlast),
    .i_rch      (i_rch),
    .o_awvalid  (o_awvalid),
    .o_awready  (o_awready),
    .o_awch     (o_awch),
    .o_wvalid   (o_wvalid),
    .o_wready   (o_wready),
    .o_wlast    (o_wlast),
    .o_wch      (o_wch),
    .o_bvalid   (o_bvalid),
    .o_bready   (o_bready),
    .o_bch      (o_bch),
    .o_arvalid  (o_arvalid),
    .o_arready  (o_arready),
    .o_arch     (o_arch),
    .o_rvalid   (o_rvalid),
    .o_rready   (o_rready),
    .o_rlast    (o_rlast),
    .o_rch      (o_rch),
    .wr_timeout (wr_timeout),
    .rd_timeout (rd_timeout)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Scoreboard: every switch-side response handshake must match the next queued one.
  always @(negedge aclk) begin
    logic [B_W-1:0] eb;
    logic [R_W:0]   er;
    if (i_bvalid && i_bready) begin
      if (exp_b.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL b_unexpected: got bch=%0h, required no response", i_bch);
      end else begin
        eb = exp_b.pop_front();
        check("b_resp", 32'(i_bch), 32'(eb));
      end
    end
    if (i_rvalid && i_rready) begin
      if (exp_r.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL r_unexpected: got rlast/rch=%0h, required no response", {i_rlast, i_rch});
      end else begin
        er = exp_r.pop_front();
        check("r_resp", 32'({i_rlast, i_rch}), 32'(er));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int n;
    srst = 1'b1;
    i_awvalid = 1'b0; i_awch = '0; i_wvalid = 1'b0; i_wlast = 1'b0; i_wch = '0;
    i_bready = 1'b1; i_arvalid = 1'b0; i_arch = '0; i_rready = 1'b1;
    o_awready = 1'b1; o_wready = 1'b1; o_bvalid = 1'b0; o_bch = '0;
    o_arready = 1'b1; o_rvalid = 1'b0; o_rlast = 1'b0; o_rch = '0;
    repeat (3) tick();
    srst = 1'b0;

    @(negedge aclk);
    check("rst_wr_timeout", 32'(wr_timeout), 0);
    check("rst_rd_timeout", 32'(rd_timeout), 0);
    check("rst_bvalid", 32'(i_bvalid), 0);
    check("rst_rvalid", 32'(i_rvalid), 0);

    // Pass-through write, then a stray B with nothing outstanding
    tick();
    i_awvalid = 1'b1; i_awch = {4'd3, 8'h10};
    @(negedge aclk);
    check("t1_awready", 32'(i_awready), 1);
    check("t1_o_awvalid", 32'(o_awvalid), 1);
    check("t1_o_awch", 32'(o_awch), 'h310);
    tick();
    i_awvalid = 1'b0; i_wvalid = 1'b1; i_wlast = 1'b1; i_wch = 8'hA5;
    @(negedge aclk);
    check("t1_o_wvalid", 32'(o_wvalid), 1);
    check("t1_o_wch", 32'(o_wch), 'hA5);
    check("t1_o_wlast", 32'(o_wlast), 1);
    check("t1_wready", 32'(i_wready), 1);
    tick();
    i_wvalid = 1'b0; i_wlast = 1'b0;
    o_bvalid = 1'b1; o_bch = {2'b00, 4'd3}; exp_b.push_back(6'h03);
    @(negedge aclk);
    check("t1_o_bready", 32'(o_bready), 1);
    tick();
    o_bch = {2'b00, 4'd10};
    @(negedge aclk);
    check("t1_stray_bvalid", 32'(i_bvalid), 0);
    check("t1_stray_bready", 32'(o_bready), 1);
    tick();
    o_bvalid = 1'b0;

    // Outstanding limit of 4
    for (int k = 0; k < 4; k++) begin
      i_awvalid = 1'b1; i_awch = {4'(k), 8'h20};
      @(negedge aclk);
      check("t2_awready_open", 32'(i_awready), 1);
      tick();
    end
    i_awch = {4'd4, 8'h20};
    for (int k = 0; k < 3; k++) begin
      @(negedge aclk);
      check("t2_full_awready", 32'(i_awready), 0);
      check("t2_full_o_awvalid", 32'(o_awvalid), 0);
      tick();
    end
    o_bvalid = 1'b1; o_bch = {2'b00, 4'd0}; exp_b.push_back(6'h00);
    @(negedge aclk);
    check("t2_full_during_b", 32'(i_awready), 0);
    tick();
    o_bvalid = 1'b0;
    @(negedge aclk);
    check("t2_accept_after_b", 32'(i_awready), 1);
    tick();
    i_awvalid = 1'b0;
    for (int k = 1; k < 5; k++) begin
      o_bvalid = 1'b1; o_bch = {2'b00, 4'(k)}; exp_b.push_back({2'b00, 4'(k)});
      tick();
    end
    o_bvalid = 1'b0;

    // Write timeout with two pending IDs
    i_awvalid = 1'b1; i_awch = {4'd1, 8'h30};
    tick();
    i_awch = {4'd2, 8'h31};
    tick();
    i_awvalid = 1'b0;
    exp_b.push_back(6'h21);
    exp_b.push_back(6'h22);
    repeat (14) tick();
    @(negedge aclk);
    check("t3_no_timeout_c15", 32'(wr_timeout), 0);
    tick();
    i_wvalid = 1'b1; i_wch = 8'h5A; i_awvalid = 1'b1; i_awch = {4'd9, 8'h32};
    @(negedge aclk);
    check("t3_timeout_c16", 32'(wr_timeout), 1);
    check("t3_flush_wready", 32'(i_wready), 1);
    check("t3_flush_o_wvalid", 32'(o_wvalid), 0);
    check("t3_flush_awready", 32'(i_awready), 0);
    check("t3_flush_o_awvalid", 32'(o_awvalid), 0);
    tick();
    i_wvalid = 1'b0; i_awvalid = 1'b0;
    repeat (2) tick();
    @(negedge aclk);
    check("t3_timeout_cleared", 32'(wr_timeout), 0);

    // Read flush mid-burst: ARLEN=3, two real beats then silence
    tick();
    i_arvalid = 1'b1; i_arch = {4'd5, 8'd3, 8'h40};
    @(negedge aclk);
    check("t4_arready", 32'(i_arready), 1);
    check("t4_o_arvalid", 32'(o_arvalid), 1);
    tick();
    i_arvalid = 1'b0;
    tick();
    o_rvalid = 1'b1; o_rlast = 1'b0; o_rch = {2'b00, 4'd5, 8'hD0};
    exp_r.push_back({1'b0, 2'b00, 4'd5, 8'hD0});
    tick();
    o_rch = {2'b00, 4'd5, 8'hD1};
    exp_r.push_back({1'b0, 2'b00, 4'd5, 8'hD1});
    tick();
    o_rvalid = 1'b0;
    exp_r.push_back({1'b0, 2'b10, 4'd5, 8'h00});
    exp_r.push_back({1'b1, 2'b10, 4'd5, 8'h00});
    n = 0;
    while (n < 40) begin
      @(negedge aclk);
      if (rd_timeout) break;
      n++;
      tick();
    end
    check("t4_flush_latency", 32'(n), 16);
    repeat (3) tick();
    @(negedge aclk);
    check("t4_rd_timeout_cleared", 32'(rd_timeout), 0);

    // Response in the watchdog expiry cycle wins
    tick();
    i_awvalid = 1'b1; i_awch = {4'd6, 8'h50};
    tick();
    i_awvalid = 1'b0;
    repeat (15) tick();
    o_bvalid = 1'b1; o_bch = {2'b00, 4'd6}; exp_b.push_back(6'h06);
    @(negedge aclk);
    check("t5_no_timeout_c15", 32'(wr_timeout), 0);
    tick();
    o_bvalid = 1'b0;
    @(negedge aclk);
    check("t5_no_flush", 32'(wr_timeout), 0);
    check("t5_no_bvalid", 32'(i_bvalid), 0);

    // Reset while both directions are flushing
    tick();
    i_bready = 1'b0; i_rready = 1'b0;
    i_awvalid = 1'b1; i_awch = {4'd7, 8'h60};
    i_arvalid = 1'b1; i_arch = {4'd8, 8'd1, 8'h70};
    tick();
    i_awvalid = 1'b0; i_arvalid = 1'b0;
    n = 0;
    while (n < 40) begin
      @(negedge aclk);
      if (wr_timeout) break;
      n++;
      tick();
    end
    check("t6_wr_flush_latency", 32'(n), 16);
    check("t6_rd_timeout", 32'(rd_timeout), 1);
    check("t6_err_bvalid", 32'(i_bvalid), 1);
    check("t6_err_bch", 32'(i_bch), 'h27);
    check("t6_err_rvalid", 32'(i_rvalid), 1);
    check("t6_err_rch", 32'(i_rch), 'h2800);
    check("t6_err_rlast", 32'(i_rlast), 0);
    tick();
    srst = 1'b1;
    tick();
    srst = 1'b0;
    @(negedge aclk);
    check("t6_rst_wr_timeout", 32'(wr_timeout), 0);
    check("t6_rst_rd_timeout", 32'(rd_timeout), 0);
    check("t6_rst_bvalid", 32'(i_bvalid), 0);
    check("t6_rst_rvalid", 32'(i_rvalid), 0);
    check("t6_rst_awready", 32'(i_awready), 1);
    tick();
    i_bready = 1'b1; i_rready = 1'b1;
    repeat (20) tick();

    check("b_queue_drained", 32'(exp_b.size()), 0);
    check("r_queue_drained", 32'(exp_r.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axicb_slv_guard.md
# axicb_slv_guard

Slave-side guard for the crossbar, placed between the switching logic and the external slave. Forwards all five AXI channels as concatenated buses. Adds three functions:
- per-direction outstanding-transaction limits;
- ID/length tracking;
- a timeout watchdog that, once a slave stops responding, completes every pending transaction with SLVERR responses.

## Interface

Parameters:
- AXI_ADDR_W, 8: address width
- AXI_ID_W, 8: ID width
- AXI_DATA_W, 8: data width
- AXI_SIGNALING, 0: 0 = AXI4-lite (len treated as 0); ≥1 = ARLEN present at arch[AXI_ADDR_W+:8]
- MAX_OSTDREQ, 4: maximum outstanding requests per direction, power of 2, ≥2
- TIMEOUT_ENABLE, 1: 0 = watchdog removed, never flushes
- TIMEOUT_CYCLES, 1024: idle-response cycles before flush, ≥2
- AWCH_W, WCH_W, BCH_W, ARCH_W, RCH_W, 8: concatenated channel widths

Ports:
- aclk, in, 1: single clock
- srst, in, 1: synchronous active-high reset
- i_aw{valid,ready,ch}, i_w{valid,ready,last,ch}, i_b{valid,ready,ch}, i_ar{valid,ready,ch}, i_r{valid,ready,last,ch}: switch side
  - i_awvalid, i_wvalid, i_wlast, i_bready, i_arvalid, i_rready and the i_awch/i_wch/i_arch buses are inputs
  - i_awready, i_wready, i_bvalid, i_arready, i_rvalid, i_rlast and the i_bch/i_rch buses are outputs
- o_aw*, o_w*, o_b*, o_ar*, o_r*: slave side, same names and widths, directions mirrored
- wr_timeout, out, 1: high while the write direction is in FLUSH
- rd_timeout, out, 1: high while the read direction is in FLUSH

Channel layout:
- AW/AR channels carry the ID in the MSBs: ID = ch[ch_W-1 -: AXI_ID_W].
- bch = {bresp, bid}
- rch = {rresp, rid, rdata}

## Operation

Write and read directions are independent, identical two-state FSMs: RUN and FLUSH.

RUN behaviour:
- **Pass-through:** all channels are combinational pass-through, with two exceptions:
  - i_awready = o_awready & !wr_full, and o_awvalid = i_awvalid & !wr_full.
  - AR is gated the same way with rd_full.
- **Request handshake:** pushes the ID into the ID FIFO and increments the outstanding count. For reads, the pushed entry also carries ARLEN.
- **Response handshake:**
  - B handshake, or R handshake with rlast: pops the FIFO and decrements the count.
  - A request and a response completing in the same cycle leave the count unchanged.
- **Read beat counter:** increments on each R handshake and clears on rlast.
- **Slave ordering:** the slave must return responses in request order per direction.
- **Stray responses:** a slave response arriving while count = 0 is absorbed (o_bready/o_rready = 1) and not forwarded.

Watchdog (per direction):
- Clears on any slave response handshake, and whenever count = 0.
- Otherwise increments each cycle.
- When it reaches TIMEOUT_CYCLES-1, the FSM enters FLUSH.

FLUSH behaviour:
- **Slave-side gating:**
  - o_awvalid/o_arvalid = 0 and i_awready/i_arready = 0.
  - o_bready/o_rready = 1; slave responses are dropped.
  - o_wvalid = 0; i_wready = 1, so W beats are accepted and dropped.
- **Write error responses:** i_bvalid = 1 with i_bch = {2'b10, FIFO head ID}. Each i_bready handshake pops the FIFO.
- **Read error responses:**
  - i_rvalid = 1, i_rch = {2'b10, head ID, zero data}.
  - Beats continue from the current beat counter.
  - i_rlast is asserted when beat == head ARLEN; that handshake pops the FIFO.
- **Exit:** return to RUN the cycle after count reaches 0.

## Timing

- **Reset:** srst clears FSMs to RUN and clears counts, FIFOs, watchdogs and beat counters.
  - Registered outputs reset to 0: wr_timeout, rd_timeout, FLUSH-sourced i_bvalid/i_rvalid.
  - Combinational outputs follow inputs from the first post-reset cycle.
  - Reset mid-transaction drops all tracked state; no responses are generated for transactions lost this way.
- **RUN latency:** zero cycles on every channel.
- **Full:** the count reaches MAX_OSTDREQ on the request handshake's clock edge, so the next request is blocked starting the following cycle.
- **Watchdog to FLUSH:** with TIMEOUT_CYCLES = N, the FSM enters FLUSH N cycles after the last response handshake (or after count went non-zero).
  - The first error response is valid in the same cycle FLUSH is entered.
- **Error-response handshakes:** one per cycle while ready is held high.
- **Simultaneous timeout expiry and slave response:** the response wins; the watchdog clears and no flush occurs.

## Structure

- **axicb_pkg** additions: localparams RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, and the FSM state enum (RUN, FLUSH).
- **Sub-module axicb_slv_id_fifo:**
  - parameters WIDTH, DEPTH
  - synchronous FIFO with full/empty flags and a show-ahead head
  - instantiated twice: write entry {ID}, read entry {ID, ARLEN}

## Test plan

- **Passthrough:** AW id=3 followed by a W beat; slave returns B OKAY.
  - i_bch = {00, 3}, same cycle as the slave B.
  - count returns to 0.
- **Outstanding limit:** MAX=4, issue 5 AW with the slave holding B.
  - Fifth request sees i_awready = 0 until the first B handshake, then is accepted the next cycle.
- **Write timeout:** TIMEOUT_CYCLES = 16, AW ids 1 and 2, slave silent.
  - wr_timeout rises at cycle 16.
  - B {10,1} then {10,2} are produced; wr_timeout falls.
- **Read flush mid-burst:** ARLEN = 3, id = 5; slave sends 2 beats, then stops.
  - Two error beats follow with rresp = 10, id = 5, rlast on the second.
- **Stray and simultaneous events:**
  - A slave B with count = 0 is absorbed; i_bvalid stays 0.
  - A response arriving in the expiry cycle prevents FLUSH.
  - srst asserted during FLUSH: all flags are 0 the next cycle.
